// File: rtl/alu_ctrl_pkg.sv
// Shared op-code and FSM state types for the ALU sequencing front-end.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_DIV  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DIV   = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/alu_ctrl_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The load edge already performs the first iteration, so last rises N-1 edges later.
module alu_ctrl_divider
    import alu_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         last
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0] step_cnt;
    logic [N-1:0] src_rem, src_quo, src_dvs;
    logic [N:0]   work;
    logic [N-1:0] diff, rem_nxt, quo_nxt;
    logic         fits;

    // Iteration operands come from the inputs on the load edge, from the registers afterwards.
    always_comb begin
        src_rem = load ? '0 : rem_q;
        src_quo = load ? dividend : quo_q;
        src_dvs = load ? divisor : dvs_q;
        work    = {src_rem, src_quo[N-1]};
        fits    = work >= {1'b0, src_dvs};
        diff    = work[N-1:0] - src_dvs;
        rem_nxt = fits ? diff : work[N-1:0];
        quo_nxt = {src_quo[N-2:0], fits};
    end

    assign last      = (step_cnt == CW'(N));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            step_cnt <= '0;
        end else if (load) begin
            rem_q    <= rem_nxt;
            quo_q    <= quo_nxt;
            dvs_q    <= divisor;
            step_cnt <= CW'(1);
        end else if (step_cnt != '0 && !last) begin
            rem_q    <= rem_nxt;
            quo_q    <= quo_nxt;
            step_cnt <= step_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_controller.sv
// Sequencing front-end for the 4-bit add/sub datapath with an internal divider.
// Division is built only when ALU_CTRL_DIV_EN is defined; otherwise op 10 behaves as reserved.
module alu_controller
    import alu_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic [1:0]   op_sel,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_carry,
    input  logic         alu_negative,
    input  logic         alu_zero,
    output logic [N-1:0] result,
    output logic [N-1:0] remainder,
    output logic         carry,
    output logic         negative,
    output logic         zero,
    output logic         overflow,
    output logic         error,
    output logic         busy,
    output logic         done
);

    state_e       state, state_nxt;
    logic         is_arith, div_go, div_by_zero;
    logic [N-1:0] div_quo, div_rem;
    logic         div_last;

    assign is_arith = (op_sel == OP_ADD) || (op_sel == OP_SUB);

`ifdef ALU_CTRL_DIV_EN
    assign div_go      = (op_sel == OP_DIV) && (op_b != '0);
    assign div_by_zero = (op_sel == OP_DIV) && (op_b == '0);

    alu_ctrl_divider #(.N(N)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state == IDLE && start && div_go),
        .dividend  (op_a),
        .divisor   (op_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );
`else
    assign div_go      = 1'b0;
    assign div_by_zero = 1'b0;
    assign div_quo     = '0;
    assign div_rem     = '0;
    assign div_last    = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = is_arith ? ISSUE : (div_go ? DIV : DONE);
            ISSUE:   state_nxt = DONE;
            DIV:     if (div_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Error outcomes are captured on the start edge itself, hence their single-edge latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            result    <= '0;
            remainder <= '0;
            carry     <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    alu_a  <= op_a;
                    alu_b  <= op_b;
                    alu_op <= op_sel;
                    if (div_by_zero) begin
                        result    <= '1;
                        remainder <= op_a;
                        carry     <= 1'b0;
                        negative  <= 1'b0;
                        zero      <= 1'b0;
                        overflow  <= 1'b1;
                        error     <= 1'b1;
                    end else if (!is_arith && !div_go) begin
                        result    <= '0;
                        remainder <= '0;
                        carry     <= 1'b0;
                        negative  <= 1'b0;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                        error     <= 1'b1;
                    end
                end
                ISSUE: begin
                    result    <= alu_result;
                    remainder <= '0;
                    carry     <= alu_carry;
                    negative  <= alu_negative;
                    zero      <= alu_zero;
                    overflow  <= 1'b0;
                    error     <= 1'b0;
                end
                DIV: if (div_last) begin
                    result    <= div_quo;
                    remainder <= div_rem;
                    carry     <= 1'b0;
                    negative  <= 1'b0;
                    zero      <= (div_quo == '0);
                    overflow  <= 1'b0;
                    error     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller (N=4): directed cases plus random ops against an arithmetic model.
module tb_alu_controller;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] op_a = '0, op_b = '0;
    logic [1:0]   op_sel = '0;
    logic [N-1:0] alu_a, alu_b, alu_result, result, remainder;
    logic [1:0]   alu_op;
    logic         alu_carry, alu_negative, alu_zero;
    logic         carry, negative, zero, overflow, error, busy, done;
    logic [N:0]   dp_w;

    int n_chk = 0;
    int n_pass = 0;

    alu_controller #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .result(result), .remainder(remainder), .carry(carry), .negative(negative),
        .zero(zero), .overflow(overflow), .error(error), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Board datapath: add, or subtract with borrow reported on carry.
    always_comb begin
        dp_w = (alu_op == 2'b01) ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    end
    assign alu_result   = dp_w[N-1:0];
    assign alu_carry    = dp_w[N];
    assign alu_negative = dp_w[N-1];
    assign alu_zero     = (dp_w[N-1:0] == '0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected outcome from arithmetic; flags packed as {carry,negative,zero,overflow,error}.
    function automatic void model(input int a, input int b, input int s,
                                  output int res, output int rem, output int fl, output int lat);
        int c, ng, z, ov, er;
        c = 0; ng = 0; z = 0; ov = 0; er = 0; res = 0; rem = 0; lat = 1;
        case (s)
            0: begin res = (a + b) % 16; c = (a + b > 15) ? 1 : 0; lat = 2; end
            1: begin res = (a - b + 16) % 16; c = (a < b) ? 1 : 0; lat = 2; end
`ifdef ALU_CTRL_DIV_EN
            2: begin
                if (b == 0) begin res = 15; rem = a; ov = 1; er = 1; end
                else begin res = a / b; rem = a % b; lat = N + 1; end
            end
`endif
            default: er = 1;
        endcase
        if (s <= 1) begin ng = (res >= 8) ? 1 : 0; z = (res == 0) ? 1 : 0; end
`ifdef ALU_CTRL_DIV_EN
        if (s == 2 && b != 0) z = (res == 0) ? 1 : 0;
`endif
        fl = c * 16 + ng * 8 + z * 4 + ov * 2 + er;
    endfunction

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s, input bit spam);
        int er, erm, ef, el, lat;
        model(int'(a), int'(b), int'(s), er, erm, ef, el);
        @(negedge clk);
        op_a = a; op_b = b; op_sel = s; start = 1'b1;
        @(negedge clk);
        lat = 1;
        if (spam) begin op_a = ~a; op_b = a; op_sel = 2'b00; end
        while (!done && lat < 20) begin
            chk("busy_wait", 32'(busy), 32'd1);
            start = spam && (lat < 3);
            @(negedge clk);
            lat++;
        end
        start = spam && (lat <= 3);
        chk("latency", 32'(lat), 32'(el));
        chk("busy_done", 32'(busy), 32'd1);
        chk("result", 32'(result), 32'(er));
        chk("remainder", 32'(remainder), 32'(erm));
        chk("flags", 32'({carry, negative, zero, overflow, error}), 32'(ef));
        chk("alu_opnds", 32'({alu_a, alu_b, alu_op}), 32'({a, b, s}));
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("result_hold", 32'(result), 32'(er));
    endtask

    initial begin
        #1;
        chk("reset_outs", 32'({alu_a, alu_b, alu_op, result, remainder, carry, negative, zero,
                              overflow, error, busy, done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd7, 4'd5, 2'b00, 1'b0);
        run_op(4'd9, 4'd7, 2'b00, 1'b0);
        run_op(4'd13, 4'd4, 2'b10, 1'b0);
        run_op(4'd3, 4'd7, 2'b10, 1'b0);
        run_op(4'd6, 4'd0, 2'b10, 1'b0);
        run_op(4'd5, 4'd2, 2'b11, 1'b0);
        run_op(4'd2, 4'd9, 2'b01, 1'b0);
        run_op(4'd15, 4'd1, 2'b10, 1'b0);
        run_op(4'd13, 4'd4, 2'b10, 1'b1);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        op_a = 4'd13; op_b = 4'd4; op_sel = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({alu_a, alu_b, alu_op, result, remainder, carry, negative, zero,
                               overflow, error, busy, done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'({done, busy}), 32'd0);
        end
        run_op(4'd8, 4'd3, 2'b01, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] ra, rb;
            logic [1:0] rs;
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 3));
            run_op(ra, rb, rs, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
